// File: rtl/in_keypad_entry.sv
// Keypad entry: signed three-digit BCD entry on switches, confirmed by a
// debounced active-low button, converted to a sign-extended binary Value.
module in_keypad_entry #(
  parameter int bits      = 32,
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flagIN,
  input  logic [3:0]      Digit,
  input  logic            Neg,
  input  logic            Key,
  output logic [bits-1:0] Value,
  output logic            Done,
  output logic            Busy,
  output logic [1:0]      Stage
);

  typedef enum logic [2:0] {
    IDLE,
    GET_H,
    GET_T,
    GET_O,
    CONVERT,
    DONE
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  state_t state;
  state_t nxt;

  logic k1;
  logic k2;
  logic db;
  logic [DB_W-1:0] cnt;
  logic hit;
  logic press;

  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] o;
  logic neg_q;
  logic valid;
  logic take;
  logic abort;
  logic [9:0] mag;
  logic [bits-1:0] ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
    end else begin
      k1 <= Key;
      k2 <= k1;
    end
  end

  // db is the debounced level: 1 = released, 0 = pressed
  assign hit   = (k2 != db) && (cnt == DB_LAST);
  assign press = hit && db;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db  <= 1'b1;
      cnt <= '0;
    end else if (k2 == db) begin
      cnt <= '0;
    end else if (hit) begin
      db  <= ~db;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  assign valid = (Digit <= 4'd9);
  assign take  = press && valid;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (flagIN) nxt = GET_H;
      GET_H:   if (!flagIN) nxt = IDLE;
               else if (take) nxt = GET_T;
      GET_T:   if (!flagIN) nxt = IDLE;
               else if (take) nxt = GET_O;
      GET_O:   if (!flagIN) nxt = IDLE;
               else if (take) nxt = CONVERT;
      CONVERT: if (!flagIN) nxt = IDLE;
               else nxt = DONE;
      DONE:    if (!flagIN) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy  = 1'b0;
    Done  = 1'b0;
    Stage = 2'd0;
    unique case (state)
      GET_H:   begin Busy = 1'b1; Stage = 2'd1; end
      GET_T:   begin Busy = 1'b1; Stage = 2'd2; end
      GET_O:   begin Busy = 1'b1; Stage = 2'd3; end
      CONVERT: begin Busy = 1'b1; Stage = 2'd3; end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign abort = !flagIN && (state == GET_H || state == GET_T ||
                             state == GET_O || state == CONVERT);

  assign mag = 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
  assign ext = {{(bits-10){1'b0}}, mag};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h     <= '0;
      t     <= '0;
      o     <= '0;
      neg_q <= 1'b0;
      Value <= '0;
    end else begin
      if (abort) begin
        h <= '0;
        t <= '0;
        o <= '0;
      end else if (take) begin
        unique case (1'b1)
          state == GET_H: h <= Digit;
          state == GET_T: t <= Digit;
          state == GET_O: begin
            o     <= Digit;
            neg_q <= Neg;
          end
          default: ;
        endcase
      end
      // negating zero yields zero, so -0 needs no special case
      if (state == CONVERT && flagIN)
        Value <= neg_q ? -ext : ext;
    end
  end

endmodule
